// File: rtl/mac_pkg.sv
// Shared constants and helpers for the parametrised multiply-accumulate unit.
package mac_pkg;

    // Operand interpretation.
    localparam int MAC_UNSIGNED = 0;
    localparam int MAC_SIGNED   = 1;

    // Accumulator overflow handling.
    localparam int MAC_WRAP = 0;
    localparam int MAC_SAT  = 1;

    // Widest accumulator the limit helpers can describe.
    localparam int MAC_MAX_ACC_W = 128;

    // Largest representable accumulator value: all ones (unsigned) or 0111..1 (signed).
    function automatic logic [MAC_MAX_ACC_W-1:0] mac_sat_max(input int acc_w, input int signed_mode);
        logic [MAC_MAX_ACC_W-1:0] v;
        int                       top;
        v   = '0;
        top = (signed_mode == MAC_SIGNED) ? acc_w - 1 : acc_w;
        for (int i = 0; i < MAC_MAX_ACC_W; i++) begin
            if (i < top) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Smallest representable accumulator value: zero (unsigned) or 1000..0 (signed).
    function automatic logic [MAC_MAX_ACC_W-1:0] mac_sat_min(input int acc_w, input int signed_mode);
        logic [MAC_MAX_ACC_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAC_MAX_ACC_W; i++) begin
            if (signed_mode == MAC_SIGNED && i == acc_w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of the MAC: registered W x W multiply with valid / clear / carry-in sideband.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int W      = 8,
    parameter int SIGNED = MAC_UNSIGNED
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_cin,
    input  logic           i_clr,
    output logic           o_valid,
    output logic [2*W-1:0] o_prod,
    output logic           o_cin,
    output logic           o_clr
);

    logic [2*W-1:0] w_prod_s;
    logic [2*W-1:0] w_prod_u;
    logic [2*W-1:0] w_prod;

    logic           r_valid;
    logic [2*W-1:0] r_prod;
    logic           r_cin;
    logic           r_clr;

    // Operands are extended to 2W first so the low 2W bits of the product are exact.
    assign w_prod_s = $signed({{W{i_a[W-1]}}, i_a}) * $signed({{W{i_b[W-1]}}, i_b});
    assign w_prod_u = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    assign w_prod   = (SIGNED == MAC_SIGNED) ? w_prod_s : w_prod_u;

    // Capture the product on valid terms; clear and valid are captured every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
            r_cin   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_clr   <= i_clr;
            if (i_valid) begin
                r_prod <= w_prod;
                r_cin  <= i_cin;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;
    assign o_cin   = r_cin;
    assign o_clr   = r_clr;

endmodule

// File: rtl/mac_pipe_param.sv
// Pipelined multiply-accumulate: stage 1 multiplies, stage 2 accumulates with
// optional saturation, a sticky overflow flag and a saturating term counter.
// ACC_W must be at least 2*W and at most MAC_MAX_ACC_W.
module mac_pipe_param
    import mac_pkg::*;
#(
    parameter int W      = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = MAC_UNSIGNED,
    parameter int SAT    = MAC_WRAP,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] out,
    output logic             cout,
    output logic             out_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] term_cnt
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(mac_sat_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(mac_sat_min(ACC_W, SIGNED));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_s1_valid;
    logic [2*W-1:0]   w_s1_prod;
    logic             w_s1_cin;
    logic             w_s1_clr;

    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_raw;
    logic             w_carry_msb;
    logic             w_ovf;
    logic [ACC_W-1:0] w_result;

    logic [ACC_W-1:0] r_out;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_ovf;
    logic [CNT_W-1:0] r_term_cnt;

    mac_mult_stage #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .i_clr   (acc_clr),
        .o_valid (w_s1_valid),
        .o_prod  (w_s1_prod),
        .o_cin   (w_s1_cin),
        .o_clr   (w_s1_clr)
    );

    // Raw ACC_W-bit add; the carry into the MSB lets signed overflow be found
    // without a second wider adder (overflow = carry into MSB xor carry out).
    always_comb begin
        w_base = w_s1_clr ? '0 : r_out;
        if (SIGNED == MAC_SIGNED) begin
            w_prod_ext = ACC_W'($signed(w_s1_prod));
        end else begin
            w_prod_ext = ACC_W'(w_s1_prod);
        end
        w_raw       = {1'b0, w_base} + {1'b0, w_prod_ext} + {{ACC_W{1'b0}}, w_s1_cin};
        w_carry_msb = w_raw[ACC_W-1] ^ w_base[ACC_W-1] ^ w_prod_ext[ACC_W-1];
        if (SIGNED == MAC_SIGNED) begin
            w_ovf = w_raw[ACC_W] ^ w_carry_msb;
        end else begin
            w_ovf = w_raw[ACC_W];
        end
    end

    // Clamp on overflow in saturating mode; signed overflow direction follows the
    // accumulator sign, since cin alone cannot overflow across differing signs.
    always_comb begin
        w_result = w_raw[ACC_W-1:0];
        if (SAT == MAC_SAT && w_ovf) begin
            if (SIGNED == MAC_SIGNED && w_base[ACC_W-1]) begin
                w_result = SAT_MIN;
            end else begin
                w_result = SAT_MAX;
            end
        end
    end

    // Stage 2: accumulate valid terms, or reset the accumulation on a lone clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_term_cnt  <= '0;
        end else if (w_s1_valid) begin
            r_out       <= w_result;
            r_cout      <= w_raw[ACC_W];
            r_out_valid <= 1'b1;
            r_ovf       <= w_s1_clr ? w_ovf : (r_ovf | w_ovf);
            if (w_s1_clr) begin
                r_term_cnt <= CNT_W'(1);
            end else if (r_term_cnt != CNT_MAX) begin
                r_term_cnt <= r_term_cnt + CNT_W'(1);
            end
        end else begin
            r_out_valid <= 1'b0;
            if (w_s1_clr) begin
                r_out      <= '0;
                r_ovf      <= 1'b0;
                r_term_cnt <= '0;
            end
        end
    end

    assign out       = r_out;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_mac_pipe_param.sv
// Directed bench for mac_pipe_param: four parameterisations share one input stream.
module tb_mac_pipe_param;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       acc_clr;

    // default: W=8, ACC_W=24, unsigned, wrap
    logic [23:0] out_def;
    logic        cout_def, ov_def, ovf_def;
    logic [7:0]  cnt_def;
    // ACC_W=16, saturating
    logic [15:0] out_sat;
    logic        cout_sat, ov_sat, ovf_sat;
    logic [7:0]  cnt_sat;
    // ACC_W=16, wrapping
    logic [15:0] out_wrp;
    logic        cout_wrp, ov_wrp, ovf_wrp;
    logic [7:0]  cnt_wrp;
    // W=8, ACC_W=24, signed
    logic [23:0] out_sgn;
    logic        cout_sgn, ov_sgn, ovf_sgn;
    logic [7:0]  cnt_sgn;

    int checks = 0;
    int errors = 0;

    mac_pipe_param #(.W(8), .ACC_W(24), .SIGNED(0), .SAT(0), .CNT_W(8)) dut_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .acc_clr(acc_clr), .out(out_def), .cout(cout_def), .out_valid(ov_def),
        .ovf(ovf_def), .term_cnt(cnt_def)
    );

    mac_pipe_param #(.W(8), .ACC_W(16), .SIGNED(0), .SAT(1), .CNT_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .acc_clr(acc_clr), .out(out_sat), .cout(cout_sat), .out_valid(ov_sat),
        .ovf(ovf_sat), .term_cnt(cnt_sat)
    );

    mac_pipe_param #(.W(8), .ACC_W(16), .SIGNED(0), .SAT(0), .CNT_W(8)) dut_wrp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .acc_clr(acc_clr), .out(out_wrp), .cout(cout_wrp), .out_valid(ov_wrp),
        .ovf(ovf_wrp), .term_cnt(cnt_wrp)
    );

    mac_pipe_param #(.W(8), .ACC_W(24), .SIGNED(1), .SAT(0), .CNT_W(8)) dut_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .acc_clr(acc_clr), .out(out_sgn), .cout(cout_sgn), .out_valid(ov_sgn),
        .ovf(ovf_sgn), .term_cnt(cnt_sgn)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one cycle of inputs
    task automatic set_in(input logic v, input logic [7:0] av, input logic [7:0] bv,
                          input logic c, input logic clr);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = c;
        acc_clr  = clr;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_def !== 24'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out_def); end
        checks++; if (cout_def !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout_def); end
        checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov_def); end
        checks++; if (ovf_def !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_def); end
        checks++; if (cnt_def !== 8'd0) begin errors++; $display("FAIL reset_term_cnt got=%0d exp=0", cnt_def); end
        checks++; if (out_sgn !== 24'd0 || out_sat !== 16'd0 || out_wrp !== 16'd0) begin
            errors++; $display("FAIL reset_out_others got=%0d/%0d/%0d exp=0", out_sgn, out_sat, out_wrp);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0]  ta [5];
        logic [7:0]  tb [5];
        logic [23:0] ex [5];
        ta = '{8'd12, 8'd8, 8'd25, 8'd100, 8'd255};
        tb = '{8'd15, 8'd10, 8'd30, 8'd50, 8'd255};
        ex = '{24'd180, 24'd260, 24'd1010, 24'd6010, 24'd71035};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) set_in(1'b1, ta[i], tb[i], 1'b0, (i == 0));
            else       set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            step();
            if (i == 0) begin
                checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL stream_latency got=%b exp=0", ov_def); end
            end else begin
                checks++; if (ov_def !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i-1, ov_def); end
                checks++; if (out_def !== ex[i-1]) begin errors++; $display("FAIL stream_out[%0d] got=%0d exp=%0d", i-1, out_def, ex[i-1]); end
                checks++; if (cnt_def !== 8'(i)) begin errors++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", i-1, cnt_def, i); end
                checks++; if (ovf_def !== 1'b0) begin errors++; $display("FAIL stream_ovf[%0d] got=%b exp=0", i-1, ovf_def); end
            end
        end
        step();
        checks++; if (ov_def !== 1'b0 || out_def !== 24'd71035) begin
            errors++; $display("FAIL stream_hold got=%b/%0d exp=0/71035", ov_def, out_def);
        end
    endtask

    // Shared stimulus for the 16-bit saturating and wrapping instances
    task automatic drive_ovf_cycle(input int i);
        case (i)
            0:       set_in(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
            1:       set_in(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
            5:       set_in(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
            default: set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        endcase
    endtask

    task automatic test_saturation();
        logic        e_ov [7];
        logic [15:0] e_out [7];
        logic        e_ovf [7];
        e_ov  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        e_out = '{16'd0, 16'd65025, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd1};
        e_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_ovf_cycle(i);
            step();
            checks++; if (ov_sat !== e_ov[i]) begin errors++; $display("FAIL sat_valid[%0d] got=%b exp=%b", i, ov_sat, e_ov[i]); end
            if (i >= 1) begin
                checks++; if (out_sat !== e_out[i]) begin errors++; $display("FAIL sat_out[%0d] got=%0d exp=%0d", i, out_sat, e_out[i]); end
                checks++; if (ovf_sat !== e_ovf[i]) begin errors++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", i, ovf_sat, e_ovf[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e_out [7];
        logic        e_ovf [7];
        e_out = '{16'd0, 16'd65025, 16'd64514, 16'd64514, 16'd64514, 16'd64514, 16'd1};
        e_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_ovf_cycle(i);
            step();
            if (i >= 1) begin
                checks++; if (out_wrp !== e_out[i]) begin errors++; $display("FAIL wrap_out[%0d] got=%0d exp=%0d", i, out_wrp, e_out[i]); end
                checks++; if (ovf_wrp !== e_ovf[i]) begin errors++; $display("FAIL wrap_ovf[%0d] got=%b exp=%b", i, ovf_wrp, e_ovf[i]); end
            end
            if (i == 1) begin
                checks++; if (cout_wrp !== 1'b0) begin errors++; $display("FAIL wrap_cout_first got=%b exp=0", cout_wrp); end
            end
            if (i == 2) begin
                checks++; if (cout_wrp !== 1'b1) begin errors++; $display("FAIL wrap_cout_second got=%b exp=1", cout_wrp); end
                checks++; if (cnt_wrp !== 8'd2) begin errors++; $display("FAIL wrap_cnt got=%0d exp=2", cnt_wrp); end
            end
        end
    endtask

    task automatic test_signed();
        logic [23:0] ex [3];
        ex = '{24'd16384, 24'd16257, 24'd16243};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       set_in(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
                1:       set_in(1'b1, 8'hFF, 8'h7F, 1'b0, 1'b0);
                2:       set_in(1'b1, 8'h03, 8'hFB, 1'b1, 1'b0);
                default: set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            endcase
            step();
            if (i >= 1) begin
                checks++; if (ov_sgn !== 1'b1) begin errors++; $display("FAIL signed_valid[%0d] got=%b exp=1", i-1, ov_sgn); end
                checks++; if (out_sgn !== ex[i-1]) begin errors++; $display("FAIL signed_out[%0d] got=%0d exp=%0d", i-1, out_sgn, ex[i-1]); end
                checks++; if (cnt_sgn !== 8'(i)) begin errors++; $display("FAIL signed_cnt[%0d] got=%0d exp=%0d", i-1, cnt_sgn, i); end
                checks++; if (ovf_sgn !== 1'b0) begin errors++; $display("FAIL signed_ovf[%0d] got=%b exp=0", i-1, ovf_sgn); end
            end
        end
        step();
    endtask

    task automatic test_bubbles();
        logic        e_ov [7];
        logic [23:0] e_out [7];
        logic [7:0]  e_cnt [7];
        e_ov  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_out = '{24'd0, 24'd6, 24'd6, 24'd6, 24'd26, 24'd0, 24'd0};
        e_cnt = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0};
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       set_in(1'b1, 8'd2, 8'd3, 1'b0, 1'b1);
                3:       set_in(1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
                4:       set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
                default: set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            endcase
            step();
            checks++; if (ov_def !== e_ov[i]) begin errors++; $display("FAIL bubble_valid[%0d] got=%b exp=%b", i, ov_def, e_ov[i]); end
            if (i >= 1) begin
                checks++; if (out_def !== e_out[i]) begin errors++; $display("FAIL bubble_out[%0d] got=%0d exp=%0d", i, out_def, e_out[i]); end
                checks++; if (cnt_def !== e_cnt[i]) begin errors++; $display("FAIL bubble_cnt[%0d] got=%0d exp=%0d", i, cnt_def, e_cnt[i]); end
            end
            if (i == 5) begin
                checks++; if (ovf_def !== 1'b0) begin errors++; $display("FAIL bubble_clr_ovf got=%b exp=0", ovf_def); end
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 8'd7, 8'd7, 1'b0, 1'b1);
        step();
        set_in(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
        step();
        checks++; if (ov_def !== 1'b1 || out_def !== 24'd49) begin
            errors++; $display("FAIL arst_pre got=%b/%0d exp=1/49", ov_def, out_def);
        end
        set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_def !== 24'd0) begin errors++; $display("FAIL arst_out got=%0d exp=0", out_def); end
        checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", ov_def); end
        checks++; if (cnt_def !== 8'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", cnt_def); end
        step();
        checks++; if (out_def !== 24'd0 || ov_def !== 1'b0) begin
            errors++; $display("FAIL arst_held got=%0d/%b exp=0/0", out_def, ov_def);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ov_def !== 1'b0 || out_def !== 24'd0) begin
                errors++; $display("FAIL arst_no_valid[%0d] got=%b/%0d exp=0/0", i, ov_def, out_def);
            end
        end
        set_in(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        step();
        checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL arst_new_early got=%b exp=0", ov_def); end
        set_in(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step();
        checks++; if (ov_def !== 1'b1 || out_def !== 24'd9 || cnt_def !== 8'd1) begin
            errors++; $display("FAIL arst_new got=%b/%0d/%0d exp=1/9/1", ov_def, out_def, cnt_def);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_saturation();
        test_wrap();
        test_signed();
        test_bubbles();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
Parametrised, pipelined multiply-accumulate unit that succeeds the fixed 8-bit Wallace/prefix-adder MAC.
- Width and accumulator width are generic; signed or unsigned operands.
- Adds a valid pipeline, an accumulator clear, an optional saturating mode with a sticky overflow flag, and a term counter.
- Sits in the datapath wherever streamed a×b products are summed (FIR taps, dot products).

Parameters:
- W, 8: operand width of a and b.
- ACC_W, 24: accumulator/output width; must be ≥ 2*W.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands, product and accumulator.
- SAT, 0: 0 = accumulator wraps modulo 2^ACC_W; 1 = clamps at the max/min representable value.
- CNT_W, 8: width of the accumulated-term counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  a, b, cin are valid this cycle
- a  in  W  multiplicand
- b  in  W  multiplier
- cin  in  1  carry-in added into the accumulate (LSB weight)
- acc_clr  in  1  start a new accumulation
- out  out  ACC_W  accumulator value
- cout  out  1  carry/borrow out of the last accumulate add (unsaturated)
- out_valid  out  1  out updated by a valid term this cycle
- ovf  out  1  sticky overflow/saturation flag
- term_cnt  out  CNT_W  number of terms in the current accumulation

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, out, cout, out_valid, ovf and term_cnt go to 0 immediately; held while low.
- Stage 1 (edge N): if in_valid, register prod = a*b (2W bits, sign per SIGNED), plus cin, acc_clr and the valid bit. If in_valid=0, the stage-1 valid bit = 0 and acc_clr is still registered.
- Stage 2 (edge N+1), when the stage-1 valid bit is set:
  - base = 0 if registered acc_clr, else out.
  - sum = base + ext(prod) + cin, with ext = sign- or zero-extension to ACC_W+1.
  - out_valid = 1 for one cycle.
- Latency: 2 cycles from input sample to out_valid. Throughput: 1 term per cycle, no stalls.
- Overflow detection:
  - Unsigned: carry out of ACC_W.
  - Signed: operand signs equal and result sign differs.
  - cout always reports the raw carry bit of the add.
- SAT=0: out = sum mod 2^ACC_W; ovf set on overflow.
- SAT=1: on overflow, out = 2^ACC_W−1 (unsigned), or signed max/min chosen by the direction of the overflow; ovf set.
- ovf is sticky and is cleared only by a registered acc_clr or by reset.
- acc_clr with in_valid: this term is the first of the new accumulation: out = prod + cin, term_cnt = 1, ovf = overflow of this term only.
- acc_clr without in_valid: at stage 2, out = 0, term_cnt = 0, ovf = 0; out_valid stays 0.
- term_cnt increments per valid term and saturates at 2^CNT_W−1 (no wrap).
- in_valid=0 bubbles: out, ovf and term_cnt hold; out_valid = 0.
- Reset mid-operation: in-flight stage-1 data is discarded. No out_valid is produced after rst_n releases until a new in_valid is seen.

Decomposition:
- Shared package mac_pkg holds:
  - the mode constants MAC_UNSIGNED / MAC_SIGNED and MAC_WRAP / MAC_SAT;
  - a function computing the saturation limits from ACC_W and SIGNED.
- One sub-module, mac_mult_stage: the registered W×W multiplier with the valid/clr/cin sideband (stage 1).
- Accumulate, saturate and count logic stays in the top module.

Test Plan:
1. Reset then stream, default params (W=8, ACC_W=24, unsigned, wrap):
   - stimulus: (12,15,clr=1), (8,10), (25,30), (100,50), (255,255), back to back;
   - required out_valid sequence of out: 180, 260, 1010, 6010, 71035;
   - required term_cnt 1..5; ovf=0; each result 2 cycles after its input.
2. Saturation, ACC_W=16, SAT=1:
   - stimulus: (255,255,clr=1), then (255,255);
   - required: out = 65025, then 65535; ovf=1 and remains 1 through bubbles;
   - next clr term (1,1) gives out=1, ovf=0.
3. Wrap, ACC_W=16, SAT=0, same stimulus as 2:
   - required: second out = (130050 mod 65536) = 64514; cout=1; ovf=1.
4. Signed, W=8, ACC_W=24, SIGNED=1:
   - stimulus: (−128,−128,clr=1), (−1,127), (3,−5) with cin=1 on the third term;
   - required out: 16384, 16257, 16243.
5. Bubbles and clr-only:
   - stimulus: valid, idle, idle, valid, then acc_clr alone;
   - required: out_valid pulses only for the valid terms; out holds across the idles; after the clr-only cycle, out=0 and term_cnt=0 with out_valid=0.
6. Asynchronous reset:
   - stimulus: assert rst_n low mid-cycle one cycle after an in_valid;
   - required: outputs go to 0 immediately; no out_valid after release until a new in_valid, which then appears 2 cycles later.
